// File: rtl/keypad_scan_if.sv
// Keypad bus between the scanner (master) and the keypad/consumer side (slave).
interface keypad_scan_if;
    logic [3:0] row;
    logic [3:0] col;
    logic       newKey;
    logic [4:0] keyCode;

    modport master (input row, output col, output newKey, output keyCode);
    modport slave  (output row, input col, input newKey, input keyCode);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with row synchronizer, press/release debounce and key encoding.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 20000
`ifdef KEYPAD_REPEAT_EN
    , parameter int unsigned REPEAT_DELAY  = 8 * DEBOUNCE,
    parameter int unsigned REPEAT_PERIOD = 2 * DEBOUNCE
`endif
) (
    input  logic          clock,
    input  logic          reset,
    keypad_scan_if.master kp
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    state_t            state, stateN;
    logic [3:0]        rowMeta, rowSync;
    logic [1:0]        k, kN;
    logic [DIV_W-1:0]  divCnt, divN;
    logic [DB_W-1:0]   dbCnt, dbN;
    logic [3:0]        rowPat, patN;
    logic [1:0]        rIdx, rN;
    logic [4:0]        keyCodeR, codeN;
    logic              newKeyR, nkN;
    logic [3:0]        rowsLow;
    logic              oneLow;
    logic [1:0]        lowIdx;

`ifdef KEYPAD_REPEAT_EN
    logic [REP_W-1:0]  repCnt, repN;
    logic              repFirst, repFirstN;
`endif

    function automatic logic [3:0] keyValue(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] v;
        case ({r, c})
            4'h0: v = 4'h1;  4'h1: v = 4'h2;  4'h2: v = 4'h3;  4'h3: v = 4'hA;
            4'h4: v = 4'h4;  4'h5: v = 4'h5;  4'h6: v = 4'h6;  4'h7: v = 4'hB;
            4'h8: v = 4'h7;  4'h9: v = 4'h8;  4'hA: v = 4'h9;  4'hB: v = 4'hC;
            4'hC: v = 4'hE;  4'hD: v = 4'h0;  4'hE: v = 4'hF;  default: v = 4'hD;
        endcase
        return v;
    endfunction

    assign rowsLow = ~rowSync;
    assign oneLow  = (rowsLow != 4'b0000) && ((rowsLow & (rowsLow - 4'd1)) == 4'b0000);

    always_comb begin
        lowIdx = 2'd0;
        case (rowsLow)
            4'b0010: lowIdx = 2'd1;
            4'b0100: lowIdx = 2'd2;
            4'b1000: lowIdx = 2'd3;
            default: lowIdx = 2'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rowMeta  <= '0;
            rowSync  <= '0;
            state    <= ST_SCAN;
            k        <= '0;
            divCnt   <= '0;
            dbCnt    <= '0;
            rowPat   <= '1;
            rIdx     <= '0;
            keyCodeR <= '0;
            newKeyR  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            repCnt   <= '0;
            repFirst <= 1'b1;
`endif
        end else begin
            rowMeta  <= kp.row;
            rowSync  <= rowMeta;
            state    <= stateN;
            k        <= kN;
            divCnt   <= divN;
            dbCnt    <= dbN;
            rowPat   <= patN;
            rIdx     <= rN;
            keyCodeR <= codeN;
            newKeyR  <= nkN;
`ifdef KEYPAD_REPEAT_EN
            repCnt   <= repN;
            repFirst <= repFirstN;
`endif
        end
    end

    always_comb begin
        stateN = state;
        kN     = k;
        divN   = divCnt;
        dbN    = dbCnt;
        patN   = rowPat;
        rN     = rIdx;
        codeN  = keyCodeR;
        nkN    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        repN      = repCnt;
        repFirstN = repFirst;
`endif
        case (state)
            ST_SCAN: begin
                if (divCnt == DIV_LAST) begin
                    divN = '0;
                    if (oneLow) begin
                        patN   = rowSync;
                        rN     = lowIdx;
                        dbN    = '0;
                        stateN = ST_DEBOUNCE;
                    end else begin
                        kN = k + 2'd1;
                    end
                end else begin
                    divN = divCnt + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (rowSync == rowPat) begin
                    if (dbCnt == DB_LAST) begin
                        nkN    = 1'b1;
                        codeN  = {1'b1, keyValue(rIdx, k)};
                        dbN    = '0;
                        stateN = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                        repN      = '0;
                        repFirstN = 1'b1;
`endif
                    end else begin
                        dbN = dbCnt + 1'b1;
                    end
                end else begin
                    dbN    = '0;
                    divN   = '0;
                    kN     = k + 2'd1;
                    stateN = ST_SCAN;
                end
            end
            ST_HELD: begin
                // Any low row (original or a second key in this column) keeps us here.
                if (rowSync == 4'b1111) begin
                    dbN    = '0;
                    stateN = ST_RELEASE;
`ifdef KEYPAD_REPEAT_EN
                    repN      = '0;
                    repFirstN = 1'b1;
`endif
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    if (repCnt == (repFirst ? REP_DELAY_LAST : REP_PERIOD_LAST)) begin
                        nkN       = 1'b1;
                        repN      = '0;
                        repFirstN = 1'b0;
                    end else begin
                        repN = repCnt + 1'b1;
                    end
`endif
                end
            end
            ST_RELEASE: begin
                if (rowSync == 4'b1111) begin
                    if (dbCnt == DB_LAST) begin
                        dbN    = '0;
                        divN   = '0;
                        kN     = k + 2'd1;
                        stateN = ST_SCAN;
                    end else begin
                        dbN = dbCnt + 1'b1;
                    end
                end else begin
                    dbN    = '0;
                    stateN = ST_HELD;
                end
            end
            default: stateN = ST_SCAN;
        endcase
        // Guarantees a gap between pulses even with a degenerate repeat period.
        if (newKeyR) nkN = 1'b0;
    end

    assign kp.col     = ~(4'b0001 << k);
    assign kp.newKey  = newKeyR;
    assign kp.keyCode = keyCodeR;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: behavioural keypad matrix plus timeline/key-layout model.
module tb_keypad_scan;

    localparam int unsigned SD = 4;
    localparam int unsigned DB = 8;
    localparam int unsigned RD = 32;
    localparam int unsigned RP = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] keyDown = '0;
    logic        prevNK = 1'b0;
    int          nChecks = 0;
    int          nFails = 0;

    keypad_scan_if kif ();

    keypad_scan #(
        .SCAN_DIV(SD),
        .DEBOUNCE(DB)
`ifdef KEYPAD_REPEAT_EN
        , .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
`endif
    ) dut (
        .clock(clock),
        .reset(reset),
        .kp(kif)
    );

    always #5 clock = ~clock;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        kif.row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keyDown[r*4+c] && !kif.col[c]) kif.row[r] = 1'b0;
    end

    always @(negedge clock) begin
        if (!reset) begin
            nChecks++;
            if (kif.col !== 4'b1110 && kif.col !== 4'b1101 && kif.col !== 4'b1011 && kif.col !== 4'b0111) begin
                nFails++;
                $display("FAIL colOneCold: col=%b, required exactly one low bit", kif.col);
            end
            if (kif.newKey === 1'b1) begin
                nChecks++;
                if (prevNK) begin
                    nFails++;
                    $display("FAIL newKeyGap: newKey high two cycles in a row at %0t", $time);
                end
            end
        end
        prevNK = (kif.newKey === 1'b1);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] expectCode(input int unsigned r, input int unsigned c);
        string layout;
        byte   ch;
        int    v;
        layout = "123A456B789CE0FD";
        ch = layout.getc(r*4 + c);
        v = (ch >= "A") ? (ch - "A" + 10) : (ch - "0");
        return {1'b1, 4'(v)};
    endfunction

    function automatic logic [3:0] idleCol(input int i);
        return ~(4'b0001 << ((i / SD) % 4));
    endfunction

    task automatic step;
        @(negedge clock);
        #1;
    endtask

    task automatic doReset;
        reset = 1'b1;
        keyDown = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic waitNewKey(input string name, output bit found);
        found = 0;
        for (int w = 0; w < 60 && !found; w++) begin
            step();
            if (kif.newKey === 1'b1) found = 1;
        end
        nChecks++;
        if (!found) begin
            nFails++;
            $display("FAIL %s: no newKey within 60 cycles", name);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        keyDown = 16'($urandom);
        step();
        keyDown = '0;
        step();
        nChecks++;
        if (kif.col !== 4'b1110 || kif.newKey !== 1'b0 || kif.keyCode !== 5'b00000) begin
            nFails++;
            $display("FAIL resetState: col=%b newKey=%b keyCode=%b, required 1110 0 00000",
                     kif.col, kif.newKey, kif.keyCode);
        end
        reset = 1'b0;
    endtask

    task automatic test_idle_scan;
        for (int i = 0; i < 20; i++) begin
            nChecks++;
            if (kif.col !== idleCol(i) || kif.newKey !== 1'b0 || kif.keyCode !== 5'b00000) begin
                nFails++;
                $display("FAIL idleScan[%0d]: col=%b newKey=%b keyCode=%b, required %b 0 00000",
                         i, kif.col, kif.newKey, kif.keyCode, idleCol(i));
            end
            step();
        end
    endtask

    task automatic test_single_key;
        int pulses = 0;
        int acceptAt = -1;
        doReset();
        keyDown[0] = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i == 20) keyDown[0] = 1'b0;
            nChecks++;
            if (kif.col !== ((i <= 30) ? 4'b1110 : 4'b1101)) begin
                nFails++;
                $display("FAIL singleKeyCol[%0d]: col=%b, required %b",
                         i, kif.col, (i <= 30) ? 4'b1110 : 4'b1101);
            end
            if (kif.newKey === 1'b1) begin
                pulses++;
                acceptAt = i;
            end
            step();
        end
        nChecks++;
        if (pulses != 1 || acceptAt != 12) begin
            nFails++;
            $display("FAIL singleKeyPulse: pulses=%0d at cycle %0d, required 1 at cycle 12", pulses, acceptAt);
        end
        nChecks++;
        if (kif.keyCode !== 5'b10001) begin
            nFails++;
            $display("FAIL singleKeyCode: keyCode=%b, required 10001", kif.keyCode);
        end
    endtask

    task automatic test_reset_priority;
        int pulses = 0;
        doReset();
        keyDown[0] = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (kif.newKey === 1'b1) pulses++;
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        keyDown[0] = 1'b0;
        nChecks++;
        if (kif.newKey !== 1'b0 || kif.keyCode !== 5'b00000 || pulses != 0) begin
            nFails++;
            $display("FAIL resetPriority: newKey=%b keyCode=%b pulses=%0d, required 0 00000 0",
                     kif.newKey, kif.keyCode, pulses);
        end
        for (int i = 0; i < 40; i++) begin
            if (kif.newKey === 1'b1) pulses++;
            step();
        end
        nChecks++;
        if (pulses != 0) begin
            nFails++;
            $display("FAIL resetDiscard: pulses=%0d after reset, required 0", pulses);
        end
    endtask

    task automatic test_bounce;
        bit seen = 0;
        int pulses = 0;
        logic [3:0] nextCol = 4'b0000;
        doReset();
        for (int w = 0; w < 40 && !seen; w++) begin
            if (kif.col === 4'b0111) seen = 1;
            else step();
        end
        nChecks++;
        if (!seen) begin
            nFails++;
            $display("FAIL bounceWait: col never reached 0111");
        end
        keyDown[15] = 1'b1;
        for (int i = 0; i < 3; i++) step();
        keyDown[15] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (kif.newKey === 1'b1) pulses++;
            if (nextCol === 4'b0000 && kif.col !== 4'b0111) nextCol = kif.col;
            step();
        end
        nChecks++;
        if (pulses != 0 || nextCol !== 4'b1110) begin
            nFails++;
            $display("FAIL bounce: pulses=%0d nextCol=%b, required 0 1110", pulses, nextCol);
        end
    endtask

    task automatic test_multi_row;
        int pulses = 0;
        doReset();
        keyDown[0*4+2] = 1'b1;
        keyDown[2*4+2] = 1'b1;
        for (int i = 0; i < 48; i++) begin
            if (kif.newKey === 1'b1) pulses++;
            nChecks++;
            if (kif.col !== idleCol(i)) begin
                nFails++;
                $display("FAIL multiRowScan[%0d]: col=%b, required %b", i, kif.col, idleCol(i));
            end
            step();
        end
        keyDown = '0;
        nChecks++;
        if (pulses != 0 || kif.keyCode !== 5'b00000) begin
            nFails++;
            $display("FAIL multiRow: pulses=%0d keyCode=%b, required 0 00000", pulses, kif.keyCode);
        end
    endtask

    task automatic test_reset_in_held;
        bit found;
        doReset();
        keyDown[3*4+1] = 1'b1;
        waitNewKey("heldAccept", found);
        nChecks++;
        if (kif.keyCode !== 5'b10000) begin
            nFails++;
            $display("FAIL heldCode: keyCode=%b, required 10000", kif.keyCode);
        end
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        nChecks++;
        if (kif.keyCode !== 5'b00000 || kif.col !== 4'b1110 || kif.newKey !== 1'b0) begin
            nFails++;
            $display("FAIL resetInHeld: keyCode=%b col=%b newKey=%b, required 00000 1110 0",
                     kif.keyCode, kif.col, kif.newKey);
        end
        waitNewKey("reacceptAfterReset", found);
        nChecks++;
        if (kif.keyCode !== 5'b10000) begin
            nFails++;
            $display("FAIL reacceptCode: keyCode=%b, required 10000", kif.keyCode);
        end
        keyDown = '0;
        for (int i = 0; i < 30; i++) step();
    endtask

    task automatic test_random_keys;
        bit found;
        int idx, idx2, hold, pulses;
        logic [4:0] exp;
        for (int n = 0; n < 10; n++) begin
            idx = $urandom_range(15);
            exp = expectCode(idx / 4, idx % 4);
            keyDown = '0;
            keyDown[idx] = 1'b1;
            waitNewKey("randomAccept", found);
            nChecks++;
            if (kif.keyCode !== exp) begin
                nFails++;
                $display("FAIL randomCode[%0d]: key %0d keyCode=%b, required %b", n, idx, kif.keyCode, exp);
            end
            hold = $urandom_range(20, 4);
            pulses = 0;
            for (int i = 0; i < hold; i++) begin
                step();
                if (i == hold / 2) begin
                    idx2 = $urandom_range(15);
                    keyDown[idx2] = 1'b1;
                end
                if (kif.newKey === 1'b1) pulses++;
            end
            keyDown = '0;
            for (int i = 0; i < 30; i++) begin
                step();
                if (kif.newKey === 1'b1) pulses++;
            end
            nChecks++;
            if (pulses != 0 || kif.keyCode !== exp) begin
                nFails++;
                $display("FAIL randomHold[%0d]: extra pulses=%0d keyCode=%b, required 0 %b",
                         n, pulses, kif.keyCode, exp);
            end
        end
    endtask

`ifdef KEYPAD_REPEAT_EN
    task automatic test_repeat;
        bit found;
        int offs[$];
        doReset();
        keyDown[1*4+1] = 1'b1;
        waitNewKey("repeatAccept", found);
        for (int i = 1; i < 80; i++) begin
            step();
            if (i == 70) keyDown = '0;
            if (kif.newKey === 1'b1) begin
                offs.push_back(i);
                nChecks++;
                if (kif.keyCode !== 5'b10101) begin
                    nFails++;
                    $display("FAIL repeatCode: offset %0d keyCode=%b, required 10101", i, kif.keyCode);
                end
            end
        end
        nChecks++;
        if (offs.size() != 3 || offs[0] != RD || offs[1] != RD + RP || offs[2] != RD + 2*RP) begin
            nFails++;
            $display("FAIL repeatTiming: %0d repeats at %p, required offsets %0d %0d %0d",
                     offs.size(), offs, RD, RD + RP, RD + 2*RP);
        end
        for (int i = 0; i < 30; i++) step();
    endtask
`else
    task automatic test_one_per_press;
        bit found;
        int pulses = 0;
        doReset();
        keyDown[1*4+1] = 1'b1;
        waitNewKey("longPressAccept", found);
        nChecks++;
        if (kif.keyCode !== 5'b10101) begin
            nFails++;
            $display("FAIL longPressCode: keyCode=%b, required 10101", kif.keyCode);
        end
        for (int i = 0; i < 100; i++) begin
            step();
            if (kif.newKey === 1'b1) pulses++;
        end
        keyDown = '0;
        nChecks++;
        if (pulses != 0) begin
            nFails++;
            $display("FAIL longPressPulses: extra pulses=%0d, required 0", pulses);
        end
        for (int i = 0; i < 30; i++) step();
    endtask
`endif

    initial begin
        test_reset();
        test_idle_scan();
        test_single_key();
        test_reset_priority();
        test_bounce();
        test_multi_row();
        test_reset_in_held();
`ifdef KEYPAD_REPEAT_EN
        test_repeat();
`else
        test_one_per_press();
`endif
        doReset();
        test_random_keys();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
